// File: rtl/pixel_readout_ctrl.sv
// Purpose: sequences one pixel frame: ERASE, EXPOSE, CONVERT (ramp count on DATA), then READ of 4 pixels.
// Latency: ERASE begins one cycle after start is seen in IDLE; each pixel strobes one cycle after its slot ends.
// Backpressure: none; start is ignored while busy and never queued.
module pixel_readout_ctrl #(
    parameter int unsigned C_ERASE   = 5,
    parameter int unsigned C_EXPOSE  = 255,
    parameter int unsigned C_CONVERT = 256,
    parameter int unsigned C_READ    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       px_reset,
    output logic       erase,
    output logic       expose,
    output logic       convert,
    output logic [3:0] read,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    output logic [7:0] pix_data,
    output logic [1:0] pix_idx,
    output logic       pix_valid,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ
    } state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [1:0]  slot, slot_n;
    logic        capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            slot  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            slot  <= slot_n;
        end
    end

    // cnt counts cycles spent in the current phase (or current READ slot)
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 32'd1;
        slot_n  = slot;
        capture = 1'b0;
        case (state)
            IDLE: begin
                cnt_n  = '0;
                slot_n = '0;
                if (start) state_n = ERASE;
            end
            ERASE: begin
                if (cnt == C_ERASE - 1) begin
                    state_n = EXPOSE;
                    cnt_n   = '0;
                end
            end
            EXPOSE: begin
                if (cnt == C_EXPOSE - 1) begin
                    state_n = CONVERT;
                    cnt_n   = '0;
                end
            end
            CONVERT: begin
                if (cnt == C_CONVERT - 1) begin
                    state_n = READ;
                    cnt_n   = '0;
                    slot_n  = '0;
                end
            end
            READ: begin
                if (cnt == C_READ - 1) begin
                    cnt_n   = '0;
                    capture = 1'b1;
                    if (slot == 2'd3) begin
                        state_n = IDLE;
                        slot_n  = '0;
                    end else begin
                        slot_n = slot + 2'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                slot_n  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_reset   <= 1'b0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            convert    <= 1'b0;
            read       <= '0;
            data_out   <= '0;
            data_oe    <= 1'b0;
            pix_data   <= '0;
            pix_idx    <= '0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            px_reset   <= (state_n == ERASE);
            erase      <= (state_n == ERASE);
            expose     <= (state_n == EXPOSE);
            convert    <= (state_n == CONVERT);
            data_oe    <= (state_n == CONVERT);
            read       <= (state_n == READ) ? (4'b0001 << slot_n) : 4'b0000;
            busy       <= (state_n != IDLE);
            pix_valid  <= capture;
            frame_done <= capture && (slot == 2'd3);
            if (state_n == CONVERT && state == CONVERT)
                data_out <= (data_out == 8'hFF) ? 8'hFF : data_out + 8'd1;
            else
                data_out <= 8'd0;
            if (capture) begin
                pix_data <= data_in;
                pix_idx  <= slot;
            end
        end
    end

endmodule

// File: doc/pixel_readout_ctrl.md
PIXEL_READOUT_CTRL -- requirements
Module: pixel_readout_ctrl

Interface
REQ-001 The block SHALL have these parameters: C_ERASE, default 5, ERASE phase length in cycles.
REQ-002 The block SHALL have these parameters: C_EXPOSE, default 255, EXPOSE phase length in cycles.
REQ-003 The block SHALL have these parameters: C_CONVERT, default 256, CONVERT phase length in cycles.
REQ-004 The block SHALL have these parameters: C_READ, default 2, length in cycles of each of the 4 READ slots.
REQ-005 The block SHALL have these ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  frame request, sampled in IDLE.
- px_reset  output  1  pixel comparator reset (to pixel RESET).
- erase  output  1  pixel ERASE.
- expose  output  1  pixel EXPOSE.
- convert  output  1  ramp/counter enable (RAMP generator gate).
- read  output  4  one-hot READ1..READ4 (bit0 = READ1).
- data_out  output  8  conversion count driven onto the pixel DATA bus.
- data_oe  output  1  DATA bus drive enable; the tri-state lives at top level.
- data_in  input  8  DATA bus as seen by the controller.
- pix_data  output  8  captured pixel code.
- pix_idx  output  2  pixel index of pix_data (0..3).
- pix_valid  output  1  one-cycle strobe, pix_data/pix_idx valid.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle strobe at end of READ.

Function
REQ-006 The FSM SHALL have the states IDLE, ERASE, EXPOSE, CONVERT and READ; all outputs SHALL be registered.
REQ-007 IDLE with start=1 SHALL enter ERASE on the next edge; start SHALL be ignored in every other state (no queuing).
REQ-008 ERASE SHALL assert erase=1 and px_reset=1 for exactly C_ERASE cycles, then enter EXPOSE.
REQ-009 EXPOSE SHALL assert expose=1 for exactly C_EXPOSE cycles, then enter CONVERT.
REQ-010 CONVERT SHALL assert convert=1 and data_oe=1 for exactly C_CONVERT cycles.
REQ-011 data_out SHALL be 0 in the first CONVERT cycle and SHALL increment by 1 per cycle, saturating at 255 with no wrap; the counter SHALL be cleared on leaving CONVERT.
REQ-012 READ SHALL comprise 4 consecutive slots of C_READ cycles each; in slot i, read SHALL equal (1<<i) and data_oe SHALL be 0.
REQ-013 On the last cycle of slot i, the block SHALL capture data_in into pix_data, set pix_idx=i, and pulse pix_valid=1 in the following cycle.
REQ-014 pix_data and pix_idx SHALL hold their values until the next capture.
REQ-015 After slot 3, the FSM SHALL return to IDLE and pulse frame_done=1 for one cycle, coincident with the pix_valid for idx 3.
REQ-016 At most one of erase, expose, convert or read[*] SHALL be non-zero in any cycle.
REQ-017 data_oe and any read bit SHALL never be high in the same cycle; the CONVERT-to-READ handover SHALL occur on a single edge.
REQ-018 Parameters SHALL satisfy: all >=1, and C_CONVERT <=256. Values outside this range are unsupported.

Reset
REQ-019 reset=1 SHALL force IDLE immediately, independent of clk.
REQ-020 While reset is asserted, all outputs SHALL be 0, including the internal counter and slot/phase counters.
REQ-021 Asserting reset mid-frame SHALL abort the frame: no pix_valid and no frame_done for that frame.
REQ-022 After reset deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-023 Defaults, start pulse at cycle 0 -> erase high cycles 1-5; expose high cycles 6-260; convert and data_oe high cycles 261-516 with data_out 0..255; read=0001 at cycles 517-518.
REQ-024 data_in forced to 8'hA5/3C/F0/0F during slots 0-3 -> pix_valid 4 times with pix_idx 0,1,2,3 and pix_data A5,3C,F0,0F; frame_done coincident with the last strobe; busy low afterwards.
REQ-025 start held high continuously -> back-to-back frames, each 1+5+255+256+8 cycles from the start edge; start pulses during busy have no effect.
REQ-026 reset asserted in cycle 300 (CONVERT) -> all outputs 0 asynchronously; no pix_valid or frame_done; a new start produces a full, correct frame.
REQ-027 C_CONVERT=300 (illegal) is not tested; C_CONVERT=10 -> data_out runs 0..9, then READ.
REQ-028 The bench SHALL assert, every cycle, the one-hot/exclusivity rules of REQ-016/REQ-017 and busy==(state!=IDLE).
